bilinear_mc: RTL and testbench

Multi-channel, flow-controlled bilinear interpolator for the camera scaling path. It blends four neighbouring pixels (a0/a1 on the top row, b0/b1 on the bottom row) for CH packed colour channels using fractional weights dx/dy. It sits between the line-buffer neighbourhood fetcher and the downstream scaler output FIFO. Compared with the single-channel, free-running interpolator, it adds per-channel lanes, full-precision intermediates with no mid-pipe truncation, optional round-to-nearest, and a valid/ready stall.

---
 rtl/bilinear_pkg.sv | 13 +
 rtl/bilinear_mc_lane.sv | 63 ++++++
 rtl/bilinear_mc.sv | 71 +++++++
 tb/tb_bilinear_mc.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bilinear_pkg.sv
// bilinear_pkg: shared stage count, scale and intermediate-width helpers for bilinear_mc
package bilinear_pkg;
  localparam int BL_STAGES = 5;
  function automatic int bl_scale(input int shift);
    return 1 << shift;
  endfunction
  function automatic int BL_HW(input int p, input int s);
    return p + s + 1;
  endfunction
  function automatic int BL_VW(input int p, input int s);
    return p + 2 * s + 2;
  endfunction
endpackage

// File: rtl/bilinear_mc_lane.sv
// bilinear_mc_lane: one channel's S2-S5 datapath (products, sums, vertical blend, round/clamp); BILINEAR_MC_ROUND_EN selects rounding
module bilinear_mc_lane
  import bilinear_pkg::*;
#(
  parameter int P_DEPTH    = 10,
  parameter int SHIFT_BITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adv,
  input  logic [P_DEPTH-1:0]    a0,
  input  logic [P_DEPTH-1:0]    a1,
  input  logic [P_DEPTH-1:0]    b0,
  input  logic [P_DEPTH-1:0]    b1,
  input  logic [SHIFT_BITS:0]   wx,
  input  logic [SHIFT_BITS:0]   dx,
  input  logic [SHIFT_BITS:0]   wy,
  input  logic [SHIFT_BITS:0]   dy,
  output logic [P_DEPTH-1:0]    c
);
  localparam int HW = BL_HW(P_DEPTH, SHIFT_BITS);
  localparam int VW = BL_VW(P_DEPTH, SHIFT_BITS);
  localparam int SW = SHIFT_BITS + 1;
  logic [HW-1:0] pa0_d, pa0_q, pa1_d, pa1_q, pb0_d, pb0_q, pb1_d, pb1_q, ht_d, ht_q, hb_d, hb_q;
  logic [SW-1:0] wy2_d, wy2_q, dy2_d, dy2_q, wy3_d, wy3_q, dy3_d, dy3_q;
  logic [VW-1:0] v0_d, v0_q, v1_d, v1_q;
  logic [P_DEPTH-1:0] c_d, c_q;
`ifdef BILINEAR_MC_ROUND_EN
  logic [P_DEPTH+1:0] v_sh;
`endif
  // next state of every stage: shift on advance, hold otherwise; intermediates are kept at full width
  always_comb begin
    pa0_d = adv ? HW'(a0) * HW'(wx) : pa0_q;
    pa1_d = adv ? HW'(a1) * HW'(dx) : pa1_q;
    pb0_d = adv ? HW'(b0) * HW'(wx) : pb0_q;
    pb1_d = adv ? HW'(b1) * HW'(dx) : pb1_q;
    wy2_d = adv ? wy : wy2_q;
    dy2_d = adv ? dy : dy2_q;
    ht_d  = adv ? pa0_q + pa1_q : ht_q;
    hb_d  = adv ? pb0_q + pb1_q : hb_q;
    wy3_d = adv ? wy2_q : wy3_q;
    dy3_d = adv ? dy2_q : dy3_q;
    v0_d  = adv ? VW'(ht_q) * VW'(wy3_q) : v0_q;
    v1_d  = adv ? VW'(hb_q) * VW'(dy3_q) : v1_q;
`ifdef BILINEAR_MC_ROUND_EN
    v_sh  = (P_DEPTH+2)'((v0_q + v1_q + (VW'(1) << (2 * SHIFT_BITS - 1))) >> (2 * SHIFT_BITS));
    c_d   = adv ? (|v_sh[P_DEPTH+1:P_DEPTH] ? '1 : v_sh[P_DEPTH-1:0]) : c_q;
`else
    c_d   = adv ? P_DEPTH'((v0_q + v1_q) >> (2 * SHIFT_BITS)) : c_q;
`endif
  end
  // stage registers, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      {pa0_q, pa1_q, pb0_q, pb1_q, ht_q, hb_q} <= '0;
      {wy2_q, dy2_q, wy3_q, dy3_q, v0_q, v1_q, c_q} <= '0;
    end else begin
      {pa0_q, pa1_q, pb0_q, pb1_q, ht_q, hb_q} <= {pa0_d, pa1_d, pb0_d, pb1_d, ht_d, hb_d};
      {wy2_q, dy2_q, wy3_q, dy3_q, v0_q, v1_q, c_q} <= {wy2_d, dy2_d, wy3_d, dy3_d, v0_d, v1_d, c_d};
    end
  end
  assign c = c_q;
endmodule

// File: rtl/bilinear_mc.sv
// bilinear_mc: CH-lane 5-stage bilinear interpolator with global valid/ready stall; BILINEAR_MC_ROUND_EN enables round-to-nearest
module bilinear_mc
  import bilinear_pkg::*;
#(
  parameter int P_DEPTH    = 10,
  parameter int SHIFT_BITS = 10,
  parameter int CH         = 3
) (
  input  logic                    p_clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CH*P_DEPTH-1:0]   in_a0,
  input  logic [CH*P_DEPTH-1:0]   in_a1,
  input  logic [CH*P_DEPTH-1:0]   in_b0,
  input  logic [CH*P_DEPTH-1:0]   in_b1,
  input  logic [SHIFT_BITS-1:0]   in_dx,
  input  logic [SHIFT_BITS-1:0]   in_dy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CH*P_DEPTH-1:0]   out_c
);
  localparam int W  = CH * P_DEPTH;
  localparam int SW = SHIFT_BITS + 1;
  localparam logic [SW-1:0] SCALE = SW'(bl_scale(SHIFT_BITS));
  logic adv;
  logic [BL_STAGES-1:0] vld_d, vld_q;
  logic [W-1:0] a0_d, a0_q, a1_d, a1_q, b0_d, b0_q, b1_d, b1_q;
  logic [SW-1:0] wx_d, wx_q, dx_d, dx_q, wy_d, wy_q, dy_d, dy_q;
  // S1 capture, weight computation and valid chain, all gated by the global advance
  always_comb begin
    adv   = ~vld_q[BL_STAGES-1] | out_ready;
    vld_d = adv ? {vld_q[BL_STAGES-2:0], in_valid} : vld_q;
    a0_d  = adv ? in_a0 : a0_q;
    a1_d  = adv ? in_a1 : a1_q;
    b0_d  = adv ? in_b0 : b0_q;
    b1_d  = adv ? in_b1 : b1_q;
    wx_d  = adv ? SCALE - SW'(in_dx) : wx_q;
    dx_d  = adv ? SW'(in_dx) : dx_q;
    wy_d  = adv ? SCALE - SW'(in_dy) : wy_q;
    dy_d  = adv ? SW'(in_dy) : dy_q;
  end
  // S1 registers and stage valids; reset drops every in-flight beat
  always_ff @(posedge p_clk) begin
    if (rst) begin
      vld_q <= '0;
      {a0_q, a1_q, b0_q, b1_q, wx_q, dx_q, wy_q, dy_q} <= '0;
    end else begin
      vld_q <= vld_d;
      {a0_q, a1_q, b0_q, b1_q, wx_q, dx_q, wy_q, dy_q} <= {a0_d, a1_d, b0_d, b1_d, wx_d, dx_d, wy_d, dy_d};
    end
  end
  assign in_ready  = adv | rst;
  assign out_valid = vld_q[BL_STAGES-1];
  for (genvar k = 0; k < CH; k++) begin : g_lane
    bilinear_mc_lane #(.P_DEPTH(P_DEPTH), .SHIFT_BITS(SHIFT_BITS)) u_lane (
      .clk (p_clk),
      .rst (rst),
      .adv (adv),
      .a0  (a0_q[k*P_DEPTH +: P_DEPTH]),
      .a1  (a1_q[k*P_DEPTH +: P_DEPTH]),
      .b0  (b0_q[k*P_DEPTH +: P_DEPTH]),
      .b1  (b1_q[k*P_DEPTH +: P_DEPTH]),
      .wx  (wx_q),
      .dx  (dx_q),
      .wy  (wy_q),
      .dy  (dy_q),
      .c   (out_c[k*P_DEPTH +: P_DEPTH])
    );
  end
endmodule

// File: tb/tb_bilinear_mc.sv
// tb_bilinear_mc: scoreboard bench for bilinear_mc against an arithmetic reference of the blend formula
module tb_bilinear_mc;
  localparam int P = 10;
  localparam int S = 10;
  localparam int CH = 3;
  localparam int W = CH * P;
  typedef struct {
    logic [W-1:0] c;
    int           acc;
  } exp_t;
  logic p_clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [W-1:0] in_a0 = '0, in_a1 = '0, in_b0 = '0, in_b1 = '0, out_c;
  logic [S-1:0] in_dx = '0, in_dy = '0;
  exp_t sb[$];
  int cyc = 0, tot = 0, bad = 0, last_lat = 0;
  logic [W-1:0] last_out = '0;

  bilinear_mc #(.P_DEPTH(P), .SHIFT_BITS(S), .CH(CH)) dut (
    .p_clk(p_clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a0(in_a0), .in_a1(in_a1), .in_b0(in_b0), .in_b1(in_b1),
    .in_dx(in_dx), .in_dy(in_dy), .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c)
  );

  always #5 p_clk = ~p_clk;
  always @(posedge p_clk) cyc <= cyc + 1;

  task automatic chk(input string n, input longint act, input longint exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", n, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model();
    logic [W-1:0] r;
    longint sc, x, y, v;
    sc = longint'(1) << S;
    x = longint'(in_dx);
    y = longint'(in_dy);
    for (int k = 0; k < CH; k++) begin
      v = longint'(in_a0[k*P +: P]) * (sc - x) * (sc - y) + longint'(in_a1[k*P +: P]) * x * (sc - y)
        + longint'(in_b0[k*P +: P]) * (sc - x) * y + longint'(in_b1[k*P +: P]) * x * y;
`ifdef BILINEAR_MC_ROUND_EN
      v = v + (sc * sc) / 2;
`endif
      v = v / (sc * sc);
      if (v > (longint'(1) << P) - 1) v = (longint'(1) << P) - 1;
      r[k*P +: P] = P'(v);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] pix(input int c0, input int c1, input int c2);
    return {P'(c2), P'(c1), P'(c0)};
  endfunction

  // Inputs are set at negedge; the handshake is judged mid-cycle and accepted beats go to the scoreboard.
  task automatic tick(output bit acc);
    #1;
    acc = !rst && in_valid && in_ready;
    if (acc) sb.push_back('{model(), cyc});
    @(negedge p_clk);
  endtask

  task automatic drain();
    bit a;
    in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 64 && sb.size() > 0; i++) tick(a);
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic one(input logic [W-1:0] a0, a1, b0, b1, input int dx, input int dy);
    bit a;
    int n;
    in_a0 = a0; in_a1 = a1; in_b0 = b0; in_b1 = b1;
    in_dx = S'(dx); in_dy = S'(dy);
    in_valid = 1;
    out_ready = 1;
    a = 0;
    for (n = 0; n < 16 && !a; n++) tick(a);
    chk("accept", a, 1);
    drain();
  endtask

  // Monitor: compares the head of the scoreboard every cycle output is valid (so held data is rechecked), pops on handshake.
  always @(negedge p_clk) begin
    #2;
    if (!rst && out_valid) begin
      if (sb.size() == 0) chk("spurious_out", 1, 0);
      else begin
        chk("out_c", out_c, sb[0].c);
        if (out_ready) begin
          last_out = out_c;
          last_lat = cyc - sb[0].acc;
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    bit a;
    int n, j;
    @(negedge p_clk);
    @(negedge p_clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_c", out_c, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 0;
    @(negedge p_clk);

    one(pix(100, 200, 300), '0, '0, '0, 0, 0);
    chk("identity", last_out, pix(100, 200, 300));
    chk("latency", last_lat, 5);

    one(pix(100, 100, 100), pix(200, 200, 200), '0, '0, 512, 0);
    chk("h_mid", last_out, pix(150, 150, 150));

    one('0, '0, '0, pix(1023, 1023, 1023), 512, 512);
`ifdef BILINEAR_MC_ROUND_EN
    chk("round", last_out, pix(256, 256, 256));
`else
    chk("round", last_out, pix(255, 255, 255));
`endif

    one(pix(1023, 1023, 1023), pix(1023, 1023, 1023), pix(1023, 1023, 1023), pix(1023, 1023, 1023), 1023, 1023);
    chk("saturate", last_out, pix(1023, 1023, 1023));

    one(pix(11, 22, 33), pix(900, 800, 700), pix(5, 6, 7), pix(1000, 999, 998), 0, 777);
    chk("dx0_left", last_out, model());

    // backpressure: 20 ramp beats with a 3-cycle downstream stall in the middle
    n = 0;
    j = 0;
    while (n < 20 && j < 100) begin
      in_valid = 1;
      in_a0 = pix(n * 50, n * 50 + 1, n * 50 + 2);
      in_a1 = pix(n * 50 + 7, n * 40, n * 30);
      in_b0 = pix(n * 30, n * 20, n * 10);
      in_b1 = pix(1023 - n * 40, 1023 - n * 30, 1023 - n * 20);
      in_dx = S'(n * 51);
      in_dy = S'(1023 - n * 50);
      out_ready = !(j >= 12 && j < 15);
      #1;
      if (!out_ready) chk("stall_in_ready", in_ready, 0);
      tick(a);
      if (a) n++;
      j++;
    end
    chk("bp_accepted", n, 20);
    drain();

    // reset with 4 beats in flight
    for (int i = 0; i < 4; i++) begin
      in_valid = 1;
      in_a0 = pix(i + 1, i + 2, i + 3);
      in_a1 = pix(500, 400, 300);
      in_dx = S'(100 * i);
      in_dy = S'(200);
      out_ready = 1;
      tick(a);
    end
    rst = 1;
    sb.delete();
    in_a0 = pix(999, 999, 999);
    out_ready = 0;
    #1;
    chk("rst_in_ready_mid", in_ready, 1);
    tick(a);
    rst = 0;
    in_valid = 0;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_c", out_c, 0);
    one(pix(321, 123, 77), pix(10, 20, 30), pix(40, 50, 60), pix(70, 80, 90), 300, 600);
    chk("post_rst_first", last_out, model());

    // randomized traffic with random stalls
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      in_a0 = W'({$urandom, $urandom});
      in_a1 = W'({$urandom, $urandom});
      in_b0 = W'({$urandom, $urandom});
      in_b1 = W'({$urandom, $urandom});
      in_dx = ($urandom % 8 == 0) ? S'(0) : ($urandom % 8 == 0) ? '1 : S'($urandom);
      in_dy = ($urandom % 8 == 0) ? S'(0) : ($urandom % 8 == 0) ? '1 : S'($urandom);
      tick(a);
    end
    drain();

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
